// File: rtl/generate_proof_deadlock_reporter_if.sv
// Report-record channel of the GenerateProof deadlock reporter.
// The producer holds a record (valid) until the consumer accepts it (ready).
interface generate_proof_deadlock_reporter_if #(
  parameter int AXIS_W = 8,
  parameter int INST_W = 11,
  parameter int CNT_W  = 16
) ();
  logic              report_valid;
  logic              report_ready;
  logic [AXIS_W-1:0] report_axis;
  logic [INST_W-1:0] report_inst;
  logic [3:0]        report_first_axis;
  logic              report_first_vld;
  logic [CNT_W-1:0]  report_seq;

  modport master (
    output report_valid,
    output report_axis,
    output report_inst,
    output report_first_axis,
    output report_first_vld,
    output report_seq,
    input  report_ready
  );

  modport slave (
    input  report_valid,
    input  report_axis,
    input  report_inst,
    input  report_first_axis,
    input  report_first_vld,
    input  report_seq,
    output report_ready
  );
endinterface

// File: rtl/generate_proof_deadlock_reporter.sv
// Filters transient stalls from the top-level deadlock monitor and, once block has
// persisted THRESHOLD cycles, emits one snapshot record and a sticky maskable interrupt.
module generate_proof_deadlock_reporter #(
  parameter int THRESHOLD = 1024,
  parameter int CNT_W     = 16,
  parameter int AXIS_W    = 8,
  parameter int INST_W    = 11
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  block,
  input  logic [AXIS_W-1:0]     axis_block_sigs,
  input  logic [INST_W-1:0]     inst_block_sigs,
  input  logic                  irq_en,
  input  logic                  flag_clear,
  generate_proof_deadlock_reporter_if.master rpt,
  output logic [CNT_W-1:0]      event_count,
  output logic [CNT_W-1:0]      episode_cycles,
  output logic                  deadlock_flag,
  output logic                  irq
);

  typedef enum logic [1:0] {IDLE, ARMED, REPORT, LATCHED} state_t;

  localparam logic [15:0] THR = 16'(THRESHOLD);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [3:0] lowest_set(input logic [AXIS_W-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = AXIS_W - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  state_t            state_q, state_d;
  logic [15:0]       persist_q, persist_d;
  logic [CNT_W-1:0]  episode_q, episode_d;
  logic [CNT_W-1:0]  event_q, event_d;
  logic              flag_q, flag_d;
  logic              rvalid_q, rvalid_d;
  logic [AXIS_W-1:0] raxis_q, raxis_d;
  logic [INST_W-1:0] rinst_q, rinst_d;
  logic [3:0]        rfirst_q, rfirst_d;
  logic              rfvld_q, rfvld_d;
  logic [CNT_W-1:0]  rseq_q, rseq_d;
  logic              declare;

  always_comb begin
    state_d   = state_q;
    persist_d = persist_q;
    episode_d = episode_q;
    event_d   = event_q;
    flag_d    = flag_q;
    rvalid_d  = rvalid_q;
    raxis_d   = raxis_q;
    rinst_d   = rinst_q;
    rfirst_d  = rfirst_q;
    rfvld_d   = rfvld_q;
    rseq_d    = rseq_q;
    declare   = 1'b0;

    case (state_q)
      IDLE: begin
        if (block) begin
          persist_d = 16'd1;
          episode_d = CNT_W'(1);
          if (THR == 16'd1) declare = 1'b1;
          else              state_d = ARMED;
        end
      end
      ARMED: begin
        if (!block) begin
          state_d   = IDLE;
          persist_d = '0;
          episode_d = '0;
        end else begin
          persist_d = persist_q + 16'd1;
          episode_d = sat_inc(episode_q);
          if (persist_d == THR) declare = 1'b1;
        end
      end
      REPORT: begin
        // A block drop here is deliberately ignored: the record must still be delivered.
        if (block) episode_d = sat_inc(episode_q);
        if (rvalid_q && rpt.report_ready) begin
          state_d  = LATCHED;
          rvalid_d = 1'b0;
        end
      end
      LATCHED: begin
        if (!block) begin
          state_d   = IDLE;
          persist_d = '0;
          episode_d = '0;
        end else begin
          episode_d = sat_inc(episode_q);
        end
      end
      default: state_d = IDLE;
    endcase

    if (flag_clear) flag_d = 1'b0;

    // Declare overrides a coincident flag_clear so a fresh deadlock is never lost.
    if (declare) begin
      state_d  = REPORT;
      rvalid_d = 1'b1;
      raxis_d  = axis_block_sigs;
      rinst_d  = inst_block_sigs;
      rfirst_d = lowest_set(axis_block_sigs);
      rfvld_d  = |axis_block_sigs;
      event_d  = sat_inc(event_q);
      rseq_d   = event_d;
      flag_d   = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      persist_q <= '0;
      episode_q <= '0;
      event_q   <= '0;
      flag_q    <= 1'b0;
      rvalid_q  <= 1'b0;
      raxis_q   <= '0;
      rinst_q   <= '0;
      rfirst_q  <= '0;
      rfvld_q   <= 1'b0;
      rseq_q    <= '0;
    end else begin
      state_q   <= state_d;
      persist_q <= persist_d;
      episode_q <= episode_d;
      event_q   <= event_d;
      flag_q    <= flag_d;
      rvalid_q  <= rvalid_d;
      raxis_q   <= raxis_d;
      rinst_q   <= rinst_d;
      rfirst_q  <= rfirst_d;
      rfvld_q   <= rfvld_d;
      rseq_q    <= rseq_d;
    end
  end

  assign rpt.report_valid      = rvalid_q;
  assign rpt.report_axis       = raxis_q;
  assign rpt.report_inst       = rinst_q;
  assign rpt.report_first_axis = rfirst_q;
  assign rpt.report_first_vld  = rfvld_q;
  assign rpt.report_seq        = rseq_q;

  assign event_count    = event_q;
  assign episode_cycles = episode_q;
  assign deadlock_flag  = flag_q;
  assign irq            = flag_q & irq_en;

endmodule

// File: tb/tb_generate_proof_deadlock_reporter.sv
// Scoreboarded bench: u4 (THRESHOLD=4, CNT_W=16) and u1 (THRESHOLD=1, CNT_W=4)
// driven with directed episodes; report records are checked at each handshake.
module tb_generate_proof_deadlock_reporter;

  typedef struct packed {
    logic [7:0]  axis;
    logic [10:0] inst;
    logic [3:0]  first;
    logic        fvld;
    logic [15:0] seq;
  } rec_t;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  logic        b4 = 0, irqen4 = 0, fc4 = 0;
  logic [7:0]  ax4 = 0;
  logic [10:0] in4 = 0;
  logic [15:0] ev4, ep4;
  logic        flag4, irq4;

  logic        b1 = 0, irqen1 = 0, fc1 = 0;
  logic [7:0]  ax1 = 0;
  logic [10:0] in1 = 0;
  logic [3:0]  ev1, ep1;
  logic        flag1, irq1;

  generate_proof_deadlock_reporter_if #(.AXIS_W(8), .INST_W(11), .CNT_W(16)) if4 ();
  generate_proof_deadlock_reporter_if #(.AXIS_W(8), .INST_W(11), .CNT_W(4))  if1 ();

  generate_proof_deadlock_reporter #(.THRESHOLD(4), .CNT_W(16), .AXIS_W(8), .INST_W(11)) u4 (
    .clock(clock), .reset(reset_n), .block(b4), .axis_block_sigs(ax4), .inst_block_sigs(in4),
    .irq_en(irqen4), .flag_clear(fc4), .rpt(if4), .event_count(ev4), .episode_cycles(ep4),
    .deadlock_flag(flag4), .irq(irq4));

  generate_proof_deadlock_reporter #(.THRESHOLD(1), .CNT_W(4), .AXIS_W(8), .INST_W(11)) u1 (
    .clock(clock), .reset(reset_n), .block(b1), .axis_block_sigs(ax1), .inst_block_sigs(in1),
    .irq_en(irqen1), .flag_clear(fc1), .rpt(if1), .event_count(ev1), .episode_cycles(ep1),
    .deadlock_flag(flag1), .irq(irq1));

  int n_cmp = 0;
  int n_bad = 0;
  rec_t q4[$];
  rec_t q1[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_rec(input string nm, input rec_t act, input rec_t exp);
    chk({nm, ".axis"},  64'(act.axis),  64'(exp.axis));
    chk({nm, ".inst"},  64'(act.inst),  64'(exp.inst));
    chk({nm, ".first"}, 64'(act.first), 64'(exp.first));
    chk({nm, ".fvld"},  64'(act.fvld),  64'(exp.fvld));
    chk({nm, ".seq"},   64'(act.seq),   64'(exp.seq));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitors: a record is consumed on the edge after valid&ready is seen here.
  logic hold4 = 0, hold1 = 0;
  always @(negedge clock) begin
    if (reset_n && hold4) chk("u4_valid_held", 64'(if4.report_valid), 64'd1);
    if (reset_n && if4.report_valid && if4.report_ready) begin
      if (q4.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL u4_report: unexpected record seq=%0d, none expected", if4.report_seq);
      end else begin
        chk_rec("u4_report", {if4.report_axis, if4.report_inst, if4.report_first_axis,
                              if4.report_first_vld, if4.report_seq}, q4.pop_front());
      end
    end
    hold4 = reset_n && if4.report_valid && !if4.report_ready;

    if (reset_n && hold1) chk("u1_valid_held", 64'(if1.report_valid), 64'd1);
    if (reset_n && if1.report_valid && if1.report_ready) begin
      if (q1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL u1_report: unexpected record seq=%0d, none expected", if1.report_seq);
      end else begin
        chk_rec("u1_report", {if1.report_axis, if1.report_inst, if1.report_first_axis,
                              if1.report_first_vld, 12'd0, if1.report_seq}, q1.pop_front());
      end
    end
    hold1 = reset_n && if1.report_valid && !if1.report_ready;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    if4.report_ready = 1'b0;
    if1.report_ready = 1'b0;
    irqen4 = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_valid", 64'(if4.report_valid), 0);
    chk("rst_flag",  64'(flag4), 0);
    chk("rst_event", 64'(ev4), 0);
    chk("rst_ep",    64'(ep4), 0);
    chk("rst_irq",   64'(irq4), 0);
    chk("rst_seq",   64'(if4.report_seq), 0);
    step(); step();
    reset_n = 1'b1;

    // Transient stall shorter than THRESHOLD
    b4 = 1;
    step(); step(); step();
    chk("short_ep3",    64'(ep4), 3);
    chk("short_valid",  64'(if4.report_valid), 0);
    b4 = 0;
    step();
    chk("short_ep0",    64'(ep4), 0);
    chk("short_valid2", 64'(if4.report_valid), 0);
    chk("short_flag",   64'(flag4), 0);
    chk("short_event",  64'(ev4), 0);
    chk("short_irq",    64'(irq4), 0);

    // Confirmed deadlock, snapshot taken on the 4th edge
    irqen4 = 0;
    b4 = 1; ax4 = 8'h01; in4 = 11'h0;
    step(); step(); step();
    chk("dl_pre_valid", 64'(if4.report_valid), 0);
    ax4 = 8'h28; in4 = 11'h5A5;
    q4.push_back({8'h28, 11'h5A5, 4'd3, 1'b1, 16'd1});
    step();
    chk("dl_valid", 64'(if4.report_valid), 1);
    chk("dl_axis",  64'(if4.report_axis), 64'h28);
    chk("dl_inst",  64'(if4.report_inst), 64'h5A5);
    chk("dl_first", 64'(if4.report_first_axis), 3);
    chk("dl_fvld",  64'(if4.report_first_vld), 1);
    chk("dl_seq",   64'(if4.report_seq), 1);
    chk("dl_flag",  64'(flag4), 1);
    chk("dl_event", 64'(ev4), 1);
    chk("dl_ep",    64'(ep4), 4);
    chk("dl_irq_masked", 64'(irq4), 0);
    irqen4 = 1;
    #1;
    chk("dl_irq_en", 64'(irq4), 1);

    // Backpressure while the sideband keeps moving
    for (int i = 0; i < 10; i++) begin
      ax4 = 8'(i * 17 + 1); in4 = 11'(i * 3);
      step();
      chk("bp_valid", 64'(if4.report_valid), 1);
      chk("bp_axis",  64'(if4.report_axis), 64'h28);
      chk("bp_inst",  64'(if4.report_inst), 64'h5A5);
    end
    if4.report_ready = 1;
    step();
    if4.report_ready = 0;
    chk("hs_valid", 64'(if4.report_valid), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("latched_valid", 64'(if4.report_valid), 0);
    end
    chk("latched_event", 64'(ev4), 1);
    chk("latched_ep",    64'(ep4), 20);
    b4 = 0;
    step();
    chk("exit_ep", 64'(ep4), 0);

    // flag_clear between episodes, then coincident with the second declare
    fc4 = 1;
    step();
    fc4 = 0;
    chk("clr_flag",  64'(flag4), 0);
    chk("clr_irq",   64'(irq4), 0);
    chk("clr_event", 64'(ev4), 1);
    b4 = 1; ax4 = 8'h80; in4 = 11'h001;
    step(); step(); step();
    fc4 = 1;
    q4.push_back({8'h80, 11'h001, 4'd7, 1'b1, 16'd2});
    step();
    fc4 = 0;
    chk("ep2_flag",  64'(flag4), 1);
    chk("ep2_event", 64'(ev4), 2);
    chk("ep2_seq",   64'(if4.report_seq), 2);
    chk("ep2_valid", 64'(if4.report_valid), 1);
    chk("ep2_first", 64'(if4.report_first_axis), 7);
    if4.report_ready = 1;
    step();
    if4.report_ready = 0;
    b4 = 0;
    step();
    chk("ep2_exit_ep", 64'(ep4), 0);

    // Asynchronous reset while a record is pending
    b4 = 1; ax4 = 8'h04;
    step(); step(); step(); step();
    chk("ep3_valid", 64'(if4.report_valid), 1);
    chk("ep3_event", 64'(ev4), 3);
    #2 reset_n = 0;
    #1;
    chk("arst_valid", 64'(if4.report_valid), 0);
    chk("arst_flag",  64'(flag4), 0);
    chk("arst_event", 64'(ev4), 0);
    chk("arst_ep",    64'(ep4), 0);
    chk("arst_irq",   64'(irq4), 0);
    step();
    chk("arst_hold_valid", 64'(if4.report_valid), 0);
    reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rearm_valid", 64'(if4.report_valid), 0);
    end
    chk("rearm_ep", 64'(ep4), 3);
    q4.push_back({8'h04, 11'h001, 4'd2, 1'b1, 16'd1});
    step();
    chk("rearm_valid4", 64'(if4.report_valid), 1);
    chk("rearm_seq",    64'(if4.report_seq), 1);
    if4.report_ready = 1;
    step();
    if4.report_ready = 0;
    b4 = 0;
    step();

    // THRESHOLD=1: single-cycle pulse with empty sideband
    irqen1 = 1;
    b1 = 1; ax1 = 8'h00; in1 = 11'h000;
    q1.push_back({8'h00, 11'h000, 4'd0, 1'b0, 16'd1});
    step();
    b1 = 0;
    chk("t1_valid", 64'(if1.report_valid), 1);
    chk("t1_fvld",  64'(if1.report_first_vld), 0);
    chk("t1_first", 64'(if1.report_first_axis), 0);
    chk("t1_event", 64'(ev1), 1);
    chk("t1_irq",   64'(irq1), 1);
    if1.report_ready = 1;
    step();
    if1.report_ready = 0;
    chk("t1_hs_valid", 64'(if1.report_valid), 0);
    step();

    // Saturation of a 4-bit event counter across 20 episodes
    for (int k = 2; k <= 20; k++) begin
      s = (k > 15) ? 15 : k;
      b1 = 1;
      ax1 = 8'h80 | (8'h01 << (k % 8));
      in1 = 11'(k);
      q1.push_back({ax1, in1, 4'(k % 8), 1'b1, 16'(s)});
      step();
      b1 = 0;
      chk("sat_seq", 64'(if1.report_seq), 64'(s));
      if1.report_ready = 1;
      step();
      if1.report_ready = 0;
      step();
    end
    chk("sat_event", 64'(ev1), 15);

    step(); step();
    chk("q4_drained", 64'(q4.size()), 0);
    chk("q1_drained", 64'(q1.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
